// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs, ALU selects, mux codes, FSM states.
// Latency: n/a (constants, types and a pure decode function only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // ALU select codes, shared with the ALU
    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_SUBU = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_ADDV = 3'b100;
    localparam logic [2:0] ALU_LUI  = 3'b101;

    // ALU B-operand mux
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    // Pure state-decoded (Moore) datapath controls
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    function automatic ctrl_t moore_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = SRCB_FOUR; c.pc_src = PCSRC_ALU; end
            S_DECODE:   c.alu_src_b = SRCB_IMM_SH2;
            S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REGB; end
            S_WB_R:     begin c.reg_we = 1'b1; c.reg_dst = 1'b1; end
            S_EXEC_I:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
            S_WB_I:     c.reg_we = 1'b1;
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
            S_MEM_RD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
            S_WB_MEM:   begin c.reg_we = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WR:   begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.iord = 1'b1; end
            S_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REGB; c.pc_src = PCSRC_ALUOUT; end
            S_JUMP:     c.pc_src = PCSRC_JUMP;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_sel_dec.sv
// ALU select / immediate-extension decode from (state, opcode, funct).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module alu_sel_dec
    import mips_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_sel_o,
    output logic       ext_zero_o
);

    // Only the execute and branch states need a non-add operation
    always_comb begin
        alu_sel_o  = ALU_ADDU;
        ext_zero_o = 1'b0;
        case (state_i)
            S_EXEC_R: begin
                case (funct_i)
                    FN_SUBU: alu_sel_o = ALU_SUBU;
                    FN_SLT:  alu_sel_o = ALU_SLT;
                    default: alu_sel_o = ALU_ADDU;
                endcase
            end
            S_EXEC_I: begin
                case (opcode_i)
                    OP_ORI:  begin alu_sel_o = ALU_OR; ext_zero_o = 1'b1; end
                    OP_ADDI: alu_sel_o = ALU_ADDV;
                    OP_LUI:  alu_sel_o = ALU_LUI;
                    default: alu_sel_o = ALU_ADDU;
                endcase
            end
            S_BRANCH: alu_sel_o = ALU_SUBU;
            default:  alu_sel_o = ALU_ADDU;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: drives datapath muxes/enables and the memory req/ready handshake.
// Latency: R/I-type 4, lw 5, sw 4, beq 3, j 3 cycles; each memory wait cycle adds one.
// Backpressure: FETCH/MEM_RD/MEM_WR hold mem_req, iord and mem_we steady until mem_ready.
module mc_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int ALUSEL_W = 3,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                mem_ready,
    input  logic                alu_zero,
    input  logic                alu_ovf,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                ext_zero,
    output logic [ALUSEL_W-1:0] alu_sel,
    output logic                reg_we,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    state_e              state_q, state_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic [ALUSEL_W-1:0] alu_sel_q;
    logic                ext_zero_q;
    logic                halted_q;
    logic [CNT_W-1:0]    retired_q;
    logic                retire;
    logic [2:0]          alu_sel_d;
    logic                ext_zero_d;

    // Next state, retirement strobe and the Moore controls for the next state.
    // FETCH only completes once its own request is visible (mem_req_q), so the
    // first cycle after reset release always presents the request first.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (ctrl_q.mem_req && mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_d = (funct == FN_ADDU || funct == FN_SUBU || funct == FN_SLT)
                                        ? S_EXEC_R : S_HALT;
                    OP_ORI, OP_ADDI, OP_LUI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:            state_d = S_MEM_ADDR;
                    OP_BEQ:                  state_d = S_BRANCH;
                    OP_J:                    state_d = S_JUMP;
                    default:                 state_d = S_HALT;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = (opcode == OP_ADDI && alu_ovf) ? S_HALT : S_WB_I;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_HALT;
        endcase
        ctrl_d = moore_ctrl(state_d);
    end

    alu_sel_dec u_alu_sel_dec (
        .state_i    (state_d),
        .opcode_i   (opcode),
        .funct_i    (funct),
        .alu_sel_o  (alu_sel_d),
        .ext_zero_o (ext_zero_d)
    );

    // State register with registered Moore outputs; reset clears every output at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            ctrl_q     <= '0;
            alu_sel_q  <= '0;
            ext_zero_q <= 1'b0;
            halted_q   <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            alu_sel_q  <= ALUSEL_W'(alu_sel_d);
            ext_zero_q <= ext_zero_d;
            halted_q   <= halted_q | (state_d == S_HALT);
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Enables that follow mem_ready / alu_zero within the same cycle
    always_comb begin
        ir_we = 1'b0;
        pc_we = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we = ctrl_q.mem_req & mem_ready;
                pc_we = ctrl_q.mem_req & mem_ready;
            end
            S_BRANCH: pc_we = alu_zero;
            S_JUMP:   pc_we = 1'b1;
            default:  pc_we = 1'b0;
        endcase
    end

    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign iord       = ctrl_q.iord;
    assign pc_src     = ctrl_q.pc_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign reg_we     = ctrl_q.reg_we;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_sel    = alu_sel_q;
    assign ext_zero   = ext_zero_q;
    assign halted     = halted_q;
    assign retired    = retired_q;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS control unit. It sits upstream of the ALU and is the initiator of the ALU select/flag interface: it drives alu_sel and the datapath muxes and enables, and consumes alu_zero and alu_ovf. It also runs a req/ready handshake to the unified instruction/data memory. It supports addu, subu, slt, ori, addi, lui, lw, sw, beq and j; any other opcode halts the core.

Parameters:
ALUSEL_W, 3, width of the ALU select bus
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
mem_ready  in  1  memory completes the current request this cycle
alu_zero  in  1  ALU zero flag, valid in the same cycle as operands
alu_ovf  in  1  ALU signed-overflow flag (valid when alu_sel=100)
mem_req  out  1  memory access request
mem_we  out  1  write qualifier for mem_req
iord  out  1  0 = address from PC, 1 = address from ALUOut
ir_we  out  1  load IR
pc_we  out  1  load PC
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
alu_src_a  out  1  0 PC, 1 regA
alu_src_b  out  2  00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2
ext_zero  out  1  1 = zero-extend imm16 (ori), 0 = sign-extend
alu_sel  out  ALUSEL_W  000 addu, 001 subu, 010 or, 011 slt, 100 add-with-ovf, 101 lui
reg_we  out  1  register file write
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = MDR, 0 = ALUOut
halted  out  1  sticky; set on overflow trap or illegal opcode
retired  out  CNT_W  count of completed instructions

Behaviour:
- Clock and reset: single clock clk, rising edge. rst_n is asynchronous and active-low.
- While rst_n=0:
  - state is FETCH; retired=0; halted=0.
  - mem_req, mem_we, ir_we, pc_we and reg_we are forced to 0.
  - All other outputs are 0.
- After reset releases, the next clk edge begins the FETCH request.
- Outputs are Moore-decoded from state, except the enables gated by mem_ready or alu_zero, which are noted per state.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_sel=000, pc_src=00.
  - ir_we = pc_we = mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_sel=000 (branch target goes to ALUOut). Next state by opcode:
  - 000000 with funct 100001/100011/101010 -> EXEC_R
  - 001101, 001000, 001111 -> EXEC_I
  - 100011, 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - anything else -> HALT
- EXEC_R: alu_src_a=1, alu_src_b=00.
  - alu_sel by funct: 100001 -> 000, 100011 -> 001, 101010 -> 011.
  - Next state WB_R.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0; retire; go to FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10.
  - ori: alu_sel=010, ext_zero=1.
  - addi: alu_sel=100.
  - lui: alu_sel=101.
  - If addi and alu_ovf=1 at the clock edge -> HALT (no register write); otherwise -> WB_I.
- WB_I: reg_we=1, reg_dst=0, mem_to_reg=0; retire; go to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_sel=000. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_req=1, iord=1. Hold until mem_ready=1, then go to WB_MEM.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1; retire; go to FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Hold until mem_ready, then retire and go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_sel=001, pc_src=01.
  - pc_we = alu_zero (Mealy).
  - Retire; go to FETCH.
- JUMP: pc_we=1, pc_src=10; retire; go to FETCH.
- HALT: halted=1; all enables 0; exit only by reset.
- Latency with mem_ready tied high, in cycles:
  - R-type 4, I-type 4, lw 5, sw 4, beq 3, j 3.
  - Each wait cycle adds 1.
- mem_req and iord/mem_we stay stable while waiting for mem_ready.
- retired increments by 1 in the cycle an instruction completes and wraps modulo 2^CNT_W.
- Overflow trap and illegal-opcode halt do not increment retired.
- rst_n asserted in any state, including mid-handshake, returns the block to FETCH within the same cycle. The memory must tolerate an abandoned request.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode and funct constants
  - ALU select codes (000-101, shared with the ALU)
  - state enumeration
  - alu_src_b and pc_src encodings
- One natural sub-module: alu_sel_dec, a combinational map (state, opcode, funct) -> alu_sel, ext_zero.

Test Plan:
- Reset and no-wait flow: rst_n low 3 cycles, then high with mem_ready=1; addu (op 000000, funct 100001) -> reg_we=1, reg_dst=1 in cycle 4; retired=1.
- Memory waits: lw with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD -> completes in 10 cycles; iord=1 and mem_req held steady throughout MEM_RD.
- beq taken/not taken: alu_zero=1 -> pc_we=1, pc_src=01 in cycle 3; alu_zero=0 -> pc_we=0; both raise retired.
- addi overflow: alu_ovf=1 in EXEC_I -> no reg_we; halted=1 from the next cycle; retired unchanged; further mem_ready pulses are ignored.
- Illegal opcode 111111 -> HALT after DECODE; the same flow with ori then lui (alu_sel 010/ext_zero=1, then 101) retires 2 instructions.
- Async reset mid-MEM_WR: drop rst_n between edges -> mem_req/mem_we go to 0 immediately; retired=0; after release, FETCH restarts.
